// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXEC control unit for the 8-bit CPU.
// Accepts instructions over a valid/ready handshake, owns the program counter,
// resolves unconditional and conditional jumps from comparator flags, stalls
// RAM stores while memory is busy and stops on HALT until reset.
// Optional feature macro: CU_SINGLE_STEP_EN (adds a 'step' input that gates
// instruction acceptance to one instruction per step pulse).

module control_sequencer #(
    parameter int OPCODE_W = 4,
    parameter int ADDR_W   = 8,
    parameter int CTRL_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid,
    input  logic [OPCODE_W-1:0] instr_opcode,
    input  logic [ADDR_W-1:0]   instr_operand,
    output logic                instr_ready,
    input  logic                flag_eq,
    input  logic                flag_lt,
    input  logic                flag_gt,
    input  logic                mem_busy,
`ifdef CU_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [CTRL_W-1:0]   ctrl_signals,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output logic                illegal
);

    // Sequencer states
    localparam logic [1:0] ST_FETCH  = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    // Control word bit positions
    localparam int BIT_A    = 0;
    localparam int BIT_B    = 1;
    localparam int BIT_Z    = 2;
    localparam int BIT_Y    = 3;
    localparam int BIT_R    = 4;
    localparam int BIT_ALU  = 5;
    localparam int BIT_SHFU = 6;
    localparam int BIT_SHFD = 7;
    localparam int BIT_RAM  = 8;
    localparam int BIT_MUXA = 9;
    localparam int BIT_MUXB = 10;
    localparam int BIT_DEX  = 11;
    localparam int BIT_JP   = 12;
    localparam int BIT_JPC  = 13;
    localparam int BIT_CMP0 = 14;
    localparam int BIT_CMP1 = 15;

    logic [1:0]          state_q;
    logic [1:0]          state_next;
    logic [OPCODE_W-1:0] opcode_q;
    logic [ADDR_W-1:0]   operand_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic [ADDR_W-1:0]   pc_q;
    logic                armed_q;
    logic                step_ok;
    logic                handshake;
    logic [CTRL_W-1:0]   decoded_word;
    logic                op_undefined;
    logic                op_halt;
    logic                store_stall;
    logic                jump_taken;
    logic [ADDR_W-1:0]   next_pc;

`ifdef CU_SINGLE_STEP_EN
    logic step_seen_q;

    // Remember a step pulse until the instruction it releases is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_seen_q <= 1'b0;
        end else if (handshake) begin
            step_seen_q <= 1'b0;
        end else if (step) begin
            step_seen_q <= 1'b1;
        end
    end

    assign step_ok = step_seen_q;
`else
    assign step_ok = 1'b1;
`endif

    // armed_q keeps instr_ready low while reset is held and for the
    // remainder of the cycle in which reset is released
    assign instr_ready  = (state_q == ST_FETCH) && armed_q && step_ok;
    assign handshake    = instr_valid && instr_ready;
    assign ctrl_signals = ctrl_q;
    assign pc           = pc_q;
    assign halted       = (state_q == ST_HALT);
    assign illegal      = (state_q == ST_DECODE) && op_undefined;

    // Only the two store opcodes carry the Ram bit, so it identifies a store
    assign store_stall  = (state_q == ST_EXEC) && ctrl_q[BIT_RAM] && mem_busy;

    // Translate the latched opcode into a control word
    always_comb begin
        logic [15:0] word16;
        word16       = 16'h0000;
        op_undefined = 1'b0;
        op_halt      = 1'b0;
        decoded_word = '0;
        if ((opcode_q >> 4) != '0) begin
            op_undefined = 1'b1;
        end else begin
            case (opcode_q[3:0])
                4'b0000: word16[BIT_R] = 1'b1;
                4'b0001: begin
                    word16[BIT_R]   = 1'b1;
                    word16[BIT_ALU] = 1'b1;
                end
                4'b0010: word16[BIT_A]    = 1'b1;
                4'b0011: word16[BIT_B]    = 1'b1;
                4'b0100: word16[BIT_Z]    = 1'b1;
                4'b0101: word16[BIT_SHFD] = 1'b1;
                4'b0110: word16[BIT_SHFU] = 1'b1;
                4'b0111: word16[BIT_Y]    = 1'b1;
                4'b1000: begin
                    word16[BIT_RAM]  = 1'b1;
                    word16[BIT_MUXB] = 1'b1;
                    word16[BIT_DEX]  = 1'b1;
                end
                4'b1001: word16[BIT_RAM] = 1'b1;
                4'b1010: begin
                    word16[BIT_Z]    = 1'b1;
                    word16[BIT_MUXA] = 1'b1;
                end
                4'b1011: word16[BIT_JP] = 1'b1;
                4'b1100: word16[BIT_JPC] = 1'b1;
                4'b1101: begin
                    word16[BIT_JPC]  = 1'b1;
                    word16[BIT_CMP0] = 1'b1;
                end
                4'b1110: begin
                    word16[BIT_JPC]  = 1'b1;
                    word16[BIT_CMP1] = 1'b1;
                end
                default: op_halt = 1'b1;
            endcase
        end
        decoded_word[15:0] = word16;
    end

    // Decide whether the instruction in EXEC redirects the program counter
    always_comb begin
        jump_taken = 1'b0;
        if (ctrl_q[BIT_JP]) begin
            jump_taken = 1'b1;
        end else if (ctrl_q[BIT_JPC]) begin
            case ({ctrl_q[BIT_CMP1], ctrl_q[BIT_CMP0]})
                2'b00:   jump_taken = flag_eq;
                2'b01:   jump_taken = flag_lt;
                2'b10:   jump_taken = flag_gt;
                default: jump_taken = 1'b0;
            endcase
        end
        next_pc = jump_taken ? operand_q : (pc_q + ADDR_W'(1));
    end

    // Sequencer next-state selection
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_FETCH:  if (handshake) state_next = ST_DECODE;
            ST_DECODE: state_next = op_halt ? ST_HALT : ST_EXEC;
            ST_EXEC:   if (!store_stall) state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            default:   state_next = ST_FETCH;
        endcase
    end

    // State register and post-reset readiness flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_next;
            armed_q <= 1'b1;
        end
    end

    // Capture the instruction fields on the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q  <= '0;
            operand_q <= '0;
        end else if (handshake) begin
            opcode_q  <= instr_opcode;
            operand_q <= instr_operand;
        end
    end

    // Control word register: loaded leaving DECODE, held through a store
    // stall, cleared everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            case (state_q)
                ST_DECODE: ctrl_q <= decoded_word;
                ST_EXEC:   if (!store_stall) ctrl_q <= '0;
                default:   ctrl_q <= '0;
            endcase
        end
    end

    // Program counter advances or jumps only when EXEC completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if ((state_q == ST_EXEC) && !store_stall) begin
            pc_q <= next_pc;
        end
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle, parametrised successor to the single-cycle opcode decoder in the 8-bit CPU.
- Runs a FETCH/DECODE/EXEC sequence with a valid/ready instruction handshake and owns the program counter.
- Resolves unconditional and conditional jumps internally from comparator flags.
- Stalls RAM stores on memory busy and supports a HALT opcode.
- Drives the same 16-bit control word to the datapath (A/B/Z/Y/R registers, ALU, shifters, RAM, muxes, comparator).

Parameters:
- OPCODE_W, 4: opcode width. Must be >= 4.
- ADDR_W, 8: program counter and jump-target width.
- CTRL_W, 16: control word width. Must be >= 16. Bits above 15 are always 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction source has a word available.
- instr_opcode  in  OPCODE_W  opcode; sampled on handshake.
- instr_operand  in  ADDR_W  jump target; sampled on handshake.
- instr_ready  out  1  sequencer accepts an instruction this cycle.
- flag_eq / flag_lt / flag_gt  in  1 each  comparator results.
- mem_busy  in  1  RAM cannot accept a write this cycle.
- ctrl_signals  out  CTRL_W  registered control word.
- pc  out  ADDR_W  program counter.
- halted  out  1  sequencer stopped.
- illegal  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; pc=0; ctrl_signals=0; instr_ready=0; halted=0; illegal=0.
  - instr_ready rises on the first clk edge after rst_n deasserts.
  - Reset mid-operation aborts the current instruction; no partial control pulse survives.
- FETCH:
  - instr_ready=1 and ctrl_signals=0.
  - On instr_valid && instr_ready: latch opcode and operand, go to DECODE. Otherwise hold.
- DECODE (1 cycle):
  - instr_ready=0.
  - Compute the control word into a register; go to EXEC.
  - Undefined opcode: illegal=1 for this cycle, word=0 (NOP).
- EXEC:
  - ctrl_signals = decoded word for exactly one cycle, except under store stall (below).
  - Store opcodes (1000, 1001) with mem_busy=1: stay in EXEC with ctrl_signals held; leave on the first cycle mem_busy=0.
  - Exit: ctrl_signals->0, state->FETCH, pc updated.
- Latency: 3 cycles minimum from handshake to the control pulse being gone.
- Control bit map:
  - 0 A, 1 B, 2 Z, 3 Y, 4 R, 5 ALU(sub), 6 ShfU, 7 ShfD, 8 Ram, 9 MuxA, 10 MuxB, 11 Dex, 12 Jp, 13 Jpc, 15:14 Comp.
- Decode table (all unlisted bits 0):
  - 0000 R. 0001 R+ALU. 0010 A. 0011 B. 0100 Z. 0101 ShfD. 0110 ShfU. 0111 Y.
  - 1000 Ram+MuxB+Dex. 1001 Ram. 1010 Z+MuxA. 1011 Jp.
  - 1100 Jpc, Comp=00. 1101 Jpc, Comp=01. 1110 Jpc, Comp=10.
  - 1111 HALT.
  - When OPCODE_W > 4, any opcode with a nonzero upper bit is undefined.
- PC update on EXEC exit:
  - Jp: pc = operand.
  - Jpc: flags are sampled in the EXEC cycle. Comp=00 jumps if flag_eq, 01 if flag_lt, 10 if flag_gt. Taken: pc = operand; not taken: pc+1.
  - All other opcodes: pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0).
- HALT:
  - DECODE -> HALT. halted=1, instr_ready=0, ctrl_signals=0, pc frozen.
  - Exits only on reset.
- Simultaneous events:
  - Flag changes outside EXEC are ignored.
  - instr_valid is ignored outside FETCH.

Optional Feature:
- Macro: CU_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - FETCH asserts instr_ready only after a step pulse has been seen since the last EXEC exit. The pulse is latched and cleared on the handshake.
  - A pulse arriving in DECODE/EXEC is latched for the next FETCH.
- Undefined:
  - No step port; FETCH asserts instr_ready unconditionally.

Test Plan:
- Reset release, then 0010 with valid held high -> instr_ready high 1 cycle after reset; ctrl_signals=16'h0001 for one cycle 2 cycles after handshake; pc 0->1.
- 1000 with mem_busy high for 3 EXEC cycles -> ctrl_signals=16'h0D00 held 4 cycles total, then 0; pc increments once.
- 1101 operand 8'h40 with flag_lt=1 -> ctrl_signals=16'h6000, pc=8'h40. Repeat with flag_lt=0 -> pc+1.
- pc=8'hFF, opcode 0000 -> ctrl_signals=16'h0010; pc wraps to 8'h00.
- 1111 -> halted=1, instr_ready stays 0 for 20 cycles; rst_n pulse low mid-EXEC of the next program -> all outputs 0 immediately, pc=0.
- OPCODE_W=6, opcode 6'b010000 -> illegal pulses 1 cycle; ctrl_signals stays 0; pc+1.
